interval_timer: RTL
===================

Name: interval_timer

Overview:
Programmable down-counting interval timer that consumes the 1 us / 1 ms / 1 s strobes produced by the free-running system time base.
- Counts a loaded period in the selected time unit, then raises a one-cycle expiry pulse and a sticky interrupt with a level acknowledge.
- Supports one-shot and periodic modes, so firmware-visible timeouts and heartbeats share one time base instead of private clock dividers.

Parameters:
WIDTH, 20, width of period and remaining-count registers (max period 2^WIDTH-1 units)
MISS_W, 8, width of saturating missed-expiry counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
usecond_pulse  in  1  one-cycle strobe, once per microsecond
msecond_pulse  in  1  one-cycle strobe, once per millisecond
second_pulse  in  1  one-cycle strobe, once per second
cfg_load  in  1  capture cfg_period/cfg_unit/cfg_periodic into shadow registers
cfg_period  in  WIDTH  period in units
cfg_unit  in  2  0=us, 1=ms, 2=s, 3=clk cycle
cfg_periodic  in  1  1=auto-reload, 0=one-shot
start  in  1  arm/re-arm timer from shadow
stop  in  1  halt timer
irq_ack  in  1  clear irq
remain  out  WIDTH  units left in current interval
busy  out  1  state==RUN
fire  out  1  one-cycle expiry pulse
irq  out  1  sticky expiry interrupt
missed_cnt  out  MISS_W  expiries occurring while irq already set, saturating
cfg_err  out  1  one-cycle pulse: start rejected (shadow period==0)

Behaviour:
- Reset values: all outputs 0; state IDLE; shadow period 0, unit 0, periodic 0.
- cfg_load: shadow <= cfg inputs next edge, accepted in any state. The running interval is not disturbed; new values apply at the next start or periodic reload. cfg_load also clears missed_cnt.
- tick = selected strobe per shadow unit (unit 3: tick=1 every cycle). Strobes are used as-is, not re-registered.
- States: IDLE, RUN, DONE.
- Priority within one cycle: rst > stop > start > tick.
- stop (any state): state->IDLE; remain holds its value; irq unaffected.
- start in any state:
  - shadow period==0: state unchanged, cfg_err=1 next cycle.
  - otherwise: remain<=shadow period, state->RUN. Restart while RUN discards the current interval.
  - Same-cycle cfg_load+start: start uses the OLD shadow.
- RUN, tick, remain>1: remain<=remain-1.
- RUN, tick, remain==1 (expiry):
  - fire=1 on the following cycle.
  - periodic: remain<=shadow period, or remain<=1 if shadow period==0 (reload never loads 0).
  - one-shot: remain<=0, state->DONE.
- DONE: counter frozen; only start or stop leave it.
- irq: set on expiry; cleared on irq_ack. Simultaneous expiry and irq_ack leaves irq=1 (set wins) with no miss counted.
- Expiry while irq==1 and no ack that cycle: missed_cnt+1, saturating at 2^MISS_W-1.
- Latency:
  - start -> busy=1 and remain valid at 1 cycle.
  - expiry tick -> fire/irq at 1 cycle.
  - Total start to fire: N ticks + 1 cycle; first-tick phase depends on strobe alignment, no resync.
- Reset mid-RUN: immediate IDLE, all outputs cleared next edge.

Decomposition:
- Package timer_pkg:
  - unit encoding constants UNIT_US/UNIT_MS/UNIT_S/UNIT_CLK
  - state encoding IDLE/RUN/DONE
- Optional sub-module timer_tick_sel: registered-free mux of strobes by unit.
- The rest is a single module.

Test Plan:
1. cfg_load period=3, unit=3, one-shot; start -> busy next cycle, remain 3,2,1,0 on consecutive cycles. fire and irq assert the cycle remain reaches 0; state DONE, busy=0.
2. period=2, unit=1 (ms), periodic; drive msecond_pulse every 5 cycles -> fire every 10 cycles. With no ack, missed_cnt increments per subsequent expiry; irq_ack coincident with an expiry keeps irq=1 and does not increment missed_cnt.
3. Mid-RUN: cfg_load period=7 while running period=4 -> current interval completes at 4, next reload uses 7.
4. stop and start asserted in same cycle as expiry tick -> stop wins: IDLE, no fire, remain held at 1.
5. start with shadow period=0 -> cfg_err pulse, state unchanged. Set MISS_W=2 and force 5 misses -> missed_cnt saturates at 3; cfg_load clears it to 0.
6. rst asserted while RUN with irq=1 -> next cycle all outputs 0, state IDLE, ticks ignored until a new start.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared encodings for the interval timer: time-unit select codes and FSM states.
package timer_pkg;

  localparam logic [1:0] UNIT_US  = 2'd0;
  localparam logic [1:0] UNIT_MS  = 2'd1;
  localparam logic [1:0] UNIT_S   = 2'd2;
  localparam logic [1:0] UNIT_CLK = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/timer_tick_sel.sv
// Combinational strobe select: picks the time-base strobe matching the unit code.
module timer_tick_sel
  import timer_pkg::*;
(
  input  logic [1:0] unit,
  input  logic       usecond_pulse,
  input  logic       msecond_pulse,
  input  logic       second_pulse,
  output logic       tick
);

  always_comb begin
    tick = 1'b0;
    case (unit)
      UNIT_US:  tick = usecond_pulse;
      UNIT_MS:  tick = msecond_pulse;
      UNIT_S:   tick = second_pulse;
      UNIT_CLK: tick = 1'b1;
      default:  tick = 1'b0;
    endcase
  end

endmodule

// File: rtl/interval_timer.sv
// Programmable down-counting interval timer driven by the system time-base strobes,
// with one-shot/periodic modes, sticky irq and a saturating missed-expiry counter.
module interval_timer
  import timer_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int MISS_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              usecond_pulse,
  input  logic              msecond_pulse,
  input  logic              second_pulse,
  input  logic              cfg_load,
  input  logic [WIDTH-1:0]  cfg_period,
  input  logic [1:0]        cfg_unit,
  input  logic              cfg_periodic,
  input  logic              start,
  input  logic              stop,
  input  logic              irq_ack,
  output logic [WIDTH-1:0]  remain,
  output logic              busy,
  output logic              fire,
  output logic              irq,
  output logic [MISS_W-1:0] missed_cnt,
  output logic              cfg_err,
  output logic [1:0]        state_dbg
);

  localparam logic [WIDTH-1:0]  ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  remain_q, remain_d;
  logic [WIDTH-1:0]  sh_period;
  logic [1:0]        sh_unit;
  logic              sh_periodic;
  logic              tick;
  logic              start_ok;
  logic              expire;
  logic              err_d;

  timer_tick_sel u_tick_sel (
    .unit          (sh_unit),
    .usecond_pulse (usecond_pulse),
    .msecond_pulse (msecond_pulse),
    .second_pulse  (second_pulse),
    .tick          (tick)
  );

  assign start_ok = start && (sh_period != '0);

  // stop beats start beats tick; a rejected start leaves the count running.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    expire   = 1'b0;
    err_d    = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start_ok) begin
      remain_d = sh_period;
      state_d  = RUN;
    end else begin
      err_d = start;
      if (state_q == RUN && tick) begin
        if (remain_q == ONE) begin
          expire = 1'b1;
          if (sh_periodic) begin
            remain_d = (sh_period == '0) ? ONE : sh_period;
          end else begin
            remain_d = '0;
            state_d  = DONE;
          end
        end else begin
          remain_d = remain_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remain_q    <= '0;
      sh_period   <= '0;
      sh_unit     <= UNIT_US;
      sh_periodic <= 1'b0;
      fire        <= 1'b0;
      irq         <= 1'b0;
      missed_cnt  <= '0;
      cfg_err     <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      fire     <= expire;
      cfg_err  <= err_d;
      if (cfg_load) begin
        sh_period   <= cfg_period;
        sh_unit     <= cfg_unit;
        sh_periodic <= cfg_periodic;
      end
      if (expire) irq <= 1'b1;
      else if (irq_ack) irq <= 1'b0;
      // An acked expiry is not a miss even though irq stays set.
      if (cfg_load) missed_cnt <= '0;
      else if (expire && irq && !irq_ack && missed_cnt != MISS_MAX)
        missed_cnt <= missed_cnt + 1'b1;
    end
  end

  assign remain    = remain_q;
  assign busy      = (state_q == RUN);
  assign state_dbg = state_q;

endmodule
